// File: rtl/regfile_write_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : regwb_pkg                                                        |
// | Purpose : Shared types and constants for the register-file write queue.   |
// |           wb_entry_t holds one queued request (up to two register writes). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package regwb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [1:0]       mask;   // [0]=lane1, [1]=lane2
    logic [WB_AW-1:0] dest1;
    logic [WB_AW-1:0] dest2;
    logic [WB_DW-1:0] data1;
    logic [WB_DW-1:0] data2;
  } wb_entry_t;

  // A lane is a forwarding candidate only when enabled, matching, and not $zero.
  function automatic logic lane_hit(input logic en,
                                    input logic [WB_AW-1:0] dest,
                                    input logic [WB_AW-1:0] addr);
    return en && (dest == addr) && (addr != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: regfile_write_queue_if                                          |
// | Purpose  : Bundles the request handshake, register-file write port,       |
// |            forwarding lookups and occupancy of the write queue.           |
// | Modports : master - request producer / decode / register file side        |
// |            slave  - the write queue itself                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface regfile_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_mask;
  logic [AW-1:0]           req_dest1;
  logic [AW-1:0]           req_dest2;
  logic [DW-1:0]           req_data1;
  logic [DW-1:0]           req_data2;
  logic                    drain_en;
  logic [AW-1:0]           wr_reg1;
  logic [AW-1:0]           wr_reg2;
  logic [DW-1:0]           wr_data1;
  logic [DW-1:0]           wr_data2;
  logic [1:0]              wr_en;
  logic [AW-1:0]           fwd_addr1;
  logic [AW-1:0]           fwd_addr2;
  logic                    fwd_hit1;
  logic                    fwd_hit2;
  logic [DW-1:0]           fwd_data1;
  logic [DW-1:0]           fwd_data2;
  logic [$clog2(DEPTH):0]  pending_count;

  modport master (
    output req_valid, req_mask, req_dest1, req_dest2, req_data1, req_data2,
    output drain_en, fwd_addr1, fwd_addr2,
    input  req_ready, wr_reg1, wr_reg2, wr_data1, wr_data2, wr_en,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending_count
  );

  modport slave (
    input  req_valid, req_mask, req_dest1, req_dest2, req_data1, req_data2,
    input  drain_en, fwd_addr1, fwd_addr2,
    output req_ready, wr_reg1, wr_reg2, wr_data1, wr_data2, wr_en,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending_count
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regwb_fifo                                                       |
// | Purpose : DEPTH-entry circular buffer of wb_entry_t. Besides the head,    |
// |           it presents every entry rotated into age order (index 0 =       |
// |           oldest) with a valid bit, so the top can run a forwarding search.|
// | Ports   : clk, rst          - clock, async active-high reset              |
// |           i_push, i_entry   - append request (ignored when full)          |
// |           i_pop             - remove head (ignored when empty)            |
// |           o_head            - current head entry                          |
// |           o_count/o_full/o_empty - occupancy                              |
// |           o_ord/o_ord_valid - all entries oldest-first with valid bits    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire wb_entry_t              i_entry,
  input  wire logic                   i_pop,
  output wb_entry_t                   o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_full,
  output logic                        o_empty,
  output wb_entry_t                   o_ord [DEPTH],
  output logic [DEPTH-1:0]            o_ord_valid
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_entry;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    logic [PW-1:0] w_idx;
    assign w_idx          = r_head + PW'(k);
    assign o_ord[k]       = r_mem[w_idx];
    assign o_ord_valid[k] = ((PW+1)'(k) < r_count);
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_write_queue                                              |
// | Purpose : Write-back queue in front of the 32x32 register file. Buffers   |
// |           dual-lane write requests, drains one per cycle into a registered |
// |           write port, and forwards the youngest pending value to decode.  |
// | Ports   : clk - clock; rst - asynchronous active-high reset               |
// |           bus - regfile_write_queue_if.slave (request, write port,        |
// |                 forwarding lookups, pending_count)                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_write_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  wire logic              clk,
  input  wire logic              rst,
  regfile_write_queue_if.slave   bus
);

  wb_entry_t              w_in;
  wb_entry_t              w_head;
  wb_entry_t              w_ord [DEPTH];
  logic [DEPTH-1:0]       w_ord_valid;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  logic [1:0]    r_wr_en;
  logic [AW-1:0] r_wr_reg1;
  logic [AW-1:0] r_wr_reg2;
  logic [DW-1:0] r_wr_data1;
  logic [DW-1:0] r_wr_data2;

  // $zero is never written: drop the enable of any lane targeting r0 on entry.
  assign w_in = '{
    mask:  {bus.req_mask[1] & (bus.req_dest2 != REG_ZERO),
            bus.req_mask[0] & (bus.req_dest1 != REG_ZERO)},
    dest1: bus.req_dest1,
    dest2: bus.req_dest2,
    data1: bus.req_data1,
    data2: bus.req_data2
  };

  // Ready depends only on stored occupancy, never on this cycle's drain.
  assign bus.req_ready = ~w_full;
  assign w_push        = bus.req_valid & ~w_full;
  assign w_pop         = bus.drain_en & ~w_empty;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_entry     (w_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ord       (w_ord),
    .o_ord_valid (w_ord_valid)
  );

  // Output stage: wr_en is a one-cycle pulse; address/data hold between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 2'b00;
      r_wr_reg1  <= '0;
      r_wr_reg2  <= '0;
      r_wr_data1 <= '0;
      r_wr_data2 <= '0;
    end else if (w_pop) begin
      r_wr_en    <= w_head.mask;
      r_wr_reg1  <= w_head.dest1;
      r_wr_reg2  <= w_head.dest2;
      r_wr_data1 <= w_head.data1;
      r_wr_data2 <= w_head.data2;
    end else begin
      r_wr_en    <= 2'b00;
    end
  end

  assign bus.wr_en         = r_wr_en;
  assign bus.wr_reg1       = r_wr_reg1;
  assign bus.wr_reg2       = r_wr_reg2;
  assign bus.wr_data1      = r_wr_data1;
  assign bus.wr_data2      = r_wr_data2;
  assign bus.pending_count = w_count;

  // Forwarding search, scanned oldest to youngest so later matches override:
  // output stage first, then queue entries in age order, lane1 before lane2.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    logic [DW-1:0] w_data;

    assign w_addr = (p == 0) ? bus.fwd_addr1 : bus.fwd_addr2;

    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      if (lane_hit(r_wr_en[0], r_wr_reg1, w_addr)) begin
        w_hit  = 1'b1;
        w_data = r_wr_data1;
      end
      if (lane_hit(r_wr_en[1], r_wr_reg2, w_addr)) begin
        w_hit  = 1'b1;
        w_data = r_wr_data2;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ord_valid[k]) begin
          if (lane_hit(w_ord[k].mask[0], w_ord[k].dest1, w_addr)) begin
            w_hit  = 1'b1;
            w_data = w_ord[k].data1;
          end
          if (lane_hit(w_ord[k].mask[1], w_ord[k].dest2, w_addr)) begin
            w_hit  = 1'b1;
            w_data = w_ord[k].data2;
          end
        end
      end
    end
  end

  assign bus.fwd_hit1  = g_fwd[0].w_hit;
  assign bus.fwd_data1 = g_fwd[0].w_data;
  assign bus.fwd_hit2  = g_fwd[1].w_hit;
  assign bus.fwd_data2 = g_fwd[1].w_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_regfile_write_queue                                           |
// | Purpose : Directed, scoreboard-checked bench for regfile_write_queue.     |
// |           Stimulus pushes the hand-computed write-port image of each      |
// |           request that must reach the register file; a negedge monitor    |
// |           pops and compares on every non-zero wr_en.                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_regfile_write_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_queue_if #(.DEPTH(4), .DW(32), .AW(5)) bus ();

  regfile_write_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // {wr_en[1:0], wr_reg1[4:0], wr_reg2[4:0], wr_data1[31:0], wr_data2[31:0]}
  logic [75:0] exp_q [$];
  logic [75:0] m_exp;
  logic [75:0] m_act;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] m, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit expect_out, input logic [1:0] en_exp);
    bus.req_mask  = m;
    bus.req_dest1 = r1;
    bus.req_dest2 = r2;
    bus.req_data1 = a;
    bus.req_data2 = b;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    if (expect_out) exp_q.push_back({en_exp, r1, r2, a, b});
  endtask

  // Monitor: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.wr_en !== 2'b00) begin
      m_act = {bus.wr_en, bus.wr_reg1, bus.wr_reg2, bus.wr_data1, bus.wr_data2};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got en=%b r1=%0d d1=0x%0h r2=%0d d2=0x%0h expected none",
                 bus.wr_en, bus.wr_reg1, bus.wr_data1, bus.wr_reg2, bus.wr_data2);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL wr_port: got en=%b r1=%0d d1=0x%0h r2=%0d d2=0x%0h expected en=%b r1=%0d d1=0x%0h r2=%0d d2=0x%0h",
                   m_act[75:74], m_act[73:69], m_act[63:32], m_act[68:64], m_act[31:0],
                   m_exp[75:74], m_exp[73:69], m_exp[63:32], m_exp[68:64], m_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_mask  = 2'b00;
    bus.req_dest1 = '0;
    bus.req_dest2 = '0;
    bus.req_data1 = '0;
    bus.req_data2 = '0;
    bus.drain_en  = 1'b0;
    bus.fwd_addr1 = '0;
    bus.fwd_addr2 = '0;
    repeat (2) tick();
    rst = 1'b0;
    at_neg();
    check("reset_count",  32'(bus.pending_count), 32'd0);
    check("reset_wr_en",  32'(bus.wr_en), 32'd0);
    check("reset_wr_reg1", 32'(bus.wr_reg1), 32'd0);
    check("reset_wr_data1", bus.wr_data1, 32'd0);
    check("reset_wr_data2", bus.wr_data2, 32'd0);
    check("reset_ready",  32'(bus.req_ready), 32'd1);
    check("reset_fwd_hit1", 32'(bus.fwd_hit1), 32'd0);

    // Single write with latency check
    bus.drain_en = 1'b1;
    push(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1, 2'b01);
    at_neg();
    check("latency_wr_en", 32'(bus.wr_en), 32'd0);
    check("latency_count", 32'(bus.pending_count), 32'd1);
    tick();
    at_neg();
    check("single_count", 32'(bus.pending_count), 32'd0);
    tick();
    at_neg();
    check("single_pulse_end", 32'(bus.wr_en), 32'd0);

    // Dual write
    push(2'b11, 5'd8, 5'd9, 32'h1, 32'h2, 1'b1, 2'b11);
    tick();
    tick();
    at_neg();
    check("dual_count", 32'(bus.pending_count), 32'd0);

    // Full / backpressure
    bus.drain_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push(2'b01, 5'(10 + i), 5'd0, 32'h100 + 32'(i), 32'h0, 1'b1, 2'b01);
    at_neg();
    check("full_ready", 32'(bus.req_ready), 32'd0);
    check("full_count", 32'(bus.pending_count), 32'd4);
    bus.fwd_addr1 = 5'd12;
    #1;
    check("full_fwd_hit", 32'(bus.fwd_hit1), 32'd1);
    check("full_fwd_data", bus.fwd_data1, 32'h102);
    bus.req_mask  = 2'b01;
    bus.req_dest1 = 5'd20;
    bus.req_dest2 = 5'd0;
    bus.req_data1 = 32'h999;
    bus.req_data2 = 32'h0;
    bus.req_valid = 1'b1;
    bus.drain_en  = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    at_neg();
    check("full_pop_count", 32'(bus.pending_count), 32'd3);
    check("full_pop_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) tick();
    at_neg();
    check("full_drained", 32'(bus.pending_count), 32'd0);

    // Forwarding priority
    bus.drain_en  = 1'b0;
    bus.fwd_addr1 = 5'd3;
    bus.fwd_addr2 = 5'd0;
    push(2'b01, 5'd3, 5'd0, 32'hA, 32'h0, 1'b1, 2'b01);
    push(2'b10, 5'd0, 5'd3, 32'h0, 32'hB, 1'b1, 2'b10);
    at_neg();
    check("fwd_young_hit", 32'(bus.fwd_hit1), 32'd1);
    check("fwd_young_data", bus.fwd_data1, 32'hB);
    check("fwd_zero_hit", 32'(bus.fwd_hit2), 32'd0);
    check("fwd_zero_data", bus.fwd_data2, 32'h0);
    push(2'b11, 5'd7, 5'd7, 32'hC, 32'hD, 1'b1, 2'b11);
    at_neg();
    bus.fwd_addr2 = 5'd7;
    #1;
    check("fwd_lane2_data", bus.fwd_data2, 32'hD);
    check("fwd_other_data", bus.fwd_data1, 32'hB);
    bus.drain_en = 1'b1;
    repeat (4) tick();
    bus.drain_en = 1'b0;
    at_neg();
    check("fwd_drained_count", 32'(bus.pending_count), 32'd0);
    check("fwd_drained_hit", 32'(bus.fwd_hit1), 32'd0);

    // $zero lane masking, then output-stage forwarding
    push(2'b11, 5'd0, 5'd4, 32'h11, 32'h44, 1'b1, 2'b10);
    bus.fwd_addr1 = 5'd0;
    bus.fwd_addr2 = 5'd4;
    at_neg();
    check("zero_fwd_hit", 32'(bus.fwd_hit1), 32'd0);
    check("zero_fwd_data", bus.fwd_data1, 32'h0);
    check("zero_lane2_hit", 32'(bus.fwd_hit2), 32'd1);
    check("zero_lane2_data", bus.fwd_data2, 32'h44);
    bus.drain_en = 1'b1;
    tick();
    bus.drain_en = 1'b0;
    at_neg();
    check("outstage_fwd_hit", 32'(bus.fwd_hit2), 32'd1);
    check("outstage_fwd_data", bus.fwd_data2, 32'h44);
    check("outstage_zero_hit", 32'(bus.fwd_hit1), 32'd0);
    tick();
    at_neg();
    check("outstage_gone_hit", 32'(bus.fwd_hit2), 32'd0);

    // Mask 00 is queued and drained without a write
    push(2'b00, 5'd6, 5'd6, 32'h66, 32'h77, 1'b0, 2'b00);
    at_neg();
    check("m00_count", 32'(bus.pending_count), 32'd1);
    bus.fwd_addr1 = 5'd6;
    #1;
    check("m00_fwd_hit", 32'(bus.fwd_hit1), 32'd0);
    bus.drain_en = 1'b1;
    tick();
    at_neg();
    check("m00_count_after", 32'(bus.pending_count), 32'd0);
    check("m00_wr_en", 32'(bus.wr_en), 32'd0);

    // Reset mid-stream discards pending writes
    bus.drain_en  = 1'b0;
    bus.fwd_addr1 = 5'd21;
    for (int i = 0; i < 3; i++)
      push(2'b01, 5'd21, 5'd0, 32'h500 + 32'(i), 32'h0, 1'b0, 2'b00);
    at_neg();
    check("pre_rst_count", 32'(bus.pending_count), 32'd3);
    check("pre_rst_fwd", bus.fwd_data1, 32'h502);
    rst = 1'b1;
    #1;
    check("rst_count", 32'(bus.pending_count), 32'd0);
    check("rst_fwd_hit", 32'(bus.fwd_hit1), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    tick();
    rst = 1'b0;
    bus.drain_en = 1'b1;
    repeat (3) tick();
    at_neg();
    check("post_rst_count", 32'(bus.pending_count), 32'd0);
    check("post_rst_wr_en", 32'(bus.wr_en), 32'd0);

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
